// File: rtl/mem_responder.sv
// Single-port word memory behind a fixed-latency request/response handshake.
// One request in flight at a time; bus inputs are sampled only on acceptance.
//
//   state | meaning
//   IDLE  | waiting for req_valid; request is captured on acceptance
//   WAIT  | latency counter running down to zero
//   RESP  | data_valid cycle; rd_data/err presented for one clock
module mem_responder #(
    parameter int    ADDR_WIDTH  = 32,
    parameter int    DATA_WIDTH  = 32,
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wrt_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  data_valid,
    output logic                  err,
    output logic                  busy
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];
    logic                    mem_we;
    logic [63:0]             word_idx;
    logic [IDX_W-1:0]        mem_idx;
    logic                    req_err;

    // Error decode works on the captured address, so it is stable for the whole request.
    assign word_idx = 64'(addr_q[ADDR_WIDTH-1:2]);
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign req_err  = (addr_q[1:0] != 2'b00) || (word_idx >= 64'(DEPTH_WORDS));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        rd_data_d    = '0;
        data_valid_d = 1'b0;
        err_d        = 1'b0;
        mem_we       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = Addr;
                    we_d    = we;
                    wdata_d = wrt_data;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d      = S_RESP;
                    data_valid_d = 1'b1;
                    err_d        = req_err;
                    if (!req_err) begin
                        if (we_q) begin
                            mem_we = 1'b1;
                        end else begin
                            rd_data_d = mem[mem_idx];
                        end
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rd_data_q    <= '0;
            data_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            rd_data_q    <= rd_data_d;
            data_valid_q <= data_valid_d;
            err_q        <= err_d;
        end
    end

    // Storage survives reset; writes only happen on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    assign rd_data    = rd_data_q;
    assign data_valid = data_valid_q;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Randomised scoreboard bench for mem_responder: a word-array reference model
// predicts each response, a negedge monitor pops and compares on data_valid.
module tb_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rv, we_i;
    logic [31:0] addr, wd;
    logic [31:0] rd;
    logic        dv, er, bz;

    logic        s_rv, s_we;
    logic [31:0] s_addr, s_wd;
    logic [31:0] rd1, rd5;
    logic        dv1, er1, bz1, dv5, er5, bz5;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(rst_n), .req_valid(rv), .Addr(addr), .we(we_i), .wrt_data(wd),
        .rd_data(rd), .data_valid(dv), .err(er), .busy(bz));

    mem_responder #(.LATENCY(1)) dut_l1 (
        .clk(clk), .reset(rst_n), .req_valid(s_rv), .Addr(s_addr), .we(s_we), .wrt_data(s_wd),
        .rd_data(rd1), .data_valid(dv1), .err(er1), .busy(bz1));

    mem_responder #(.LATENCY(5)) dut_l5 (
        .clk(clk), .reset(rst_n), .req_valid(s_rv), .Addr(s_addr), .we(s_we), .wrt_data(s_wd),
        .rd_data(rd5), .data_valid(dv5), .err(er5), .busy(bz5));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: sequential word array; a request either errors, reads, or writes.
    task automatic predict(input logic w, input logic [31:0] a, input logic [31:0] d, input int acc);
        exp_t e;
        int   idx;
        idx   = int'(a >> 2);
        e.cyc = acc + LAT;
        e.err = (a % 4 != 0) || (a / 4 >= DEPTH);
        e.rd  = 32'h0;
        if (!e.err) begin
            if (w) model[idx] = d;
            else   e.rd = model[idx];
        end
        exp_q.push_back(e);
    endtask

    // Presents one request; during WAIT/RESP the bus carries junk, with req_valid held if hold=1.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input bit hold);
        @(negedge clk);
        chk("busy_idle", bz, 0);
        rv = 1'b1; we_i = w; addr = a; wd = d;
        predict(w, a, d, cyc + 1);
        for (int i = 0; i < LAT + 1; i++) begin
            @(negedge clk);
            chk("busy_active", bz, 1);
            rv = hold; we_i = 1'($urandom); addr = $urandom & 32'h0000_00FC; wd = $urandom;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rv = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r = int'($urandom_range(0, 9));
        if (r < 6)  return 32'($urandom_range(0, DEPTH - 1)) * 4;
        if (r < 8)  return (32'($urandom_range(0, DEPTH - 1)) * 4) | 32'($urandom_range(1, 3));
        if (r == 8) return 32'(4 * DEPTH) + 32'($urandom_range(0, 50)) * 4;
        return $urandom | 32'h0100_0000;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (dv) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_data_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("dv_cycle", 64'(cyc), 64'(e.cyc));
                    chk("err", er, e.err);
                    chk("rd_data", rd, e.rd);
                end
            end else begin
                chk("idle_rd_data", rd, 0);
                chk("idle_err", er, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] old20, a;
        rst_n = 1'b0; rv = 1'b0; we_i = 1'b0; addr = '0; wd = '0;
        s_rv = 1'b0; s_we = 1'b0; s_addr = '0; s_wd = '0;
        #1;
        chk("reset_dv", dv, 0);
        chk("reset_err", er, 0);
        chk("reset_busy", bz, 0);
        chk("reset_rd", rd, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) do_req(1'b1, 32'(i * 4), $urandom, 1'b0);

        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b0, 32'h3, 32'h0, 1'b0);
        do_req(1'b1, 32'(4 * DEPTH), $urandom, 1'b0);
        do_req(1'b0, 32'h0, 32'h0, 1'b0);

        // Write accepted, then reset in WAIT: nothing may be written or reported.
        old20 = model[8];
        @(negedge clk);
        rv = 1'b1; we_i = 1'b1; addr = 32'h20; wd = 32'h1234_5678;
        @(negedge clk);
        rv = 1'b0;
        chk("rst_busy_before", bz, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy_async", bz, 0);
        chk("rst_dv_async", dv, 0);
        chk("rst_rd_async", rd, 0);
        chk("rst_err_async", er, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, 32'h20, 32'h0, 1'b0);
        chk("model_0x20_kept", model[8], old20);

        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            s_rv = 1'b1; s_we = (pass == 0); s_addr = (pass == 0) ? 32'h0 : 32'h3; s_wd = $urandom;
            @(negedge clk);
            s_rv = 1'b0;
            for (int j = 1; j <= 8; j++) begin
                chk("l1_dv", dv1, j == 2);
                chk("l1_busy", bz1, j <= 2);
                chk("l1_err", er1, (pass == 1) && (j == 2));
                chk("l1_rd", rd1, 0);
                chk("l5_dv", dv5, j == 6);
                chk("l5_busy", bz5, j <= 6);
                chk("l5_err", er5, (pass == 1) && (j == 6));
                chk("l5_rd", rd5, 0);
                @(negedge clk);
            end
        end

        for (int i = 0; i < 200; i++) begin
            do_req(1'($urandom), rand_addr(), $urandom, 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        a = 32'($urandom_range(0, DEPTH - 1)) * 4;
        for (int p = 0; p < 10; p++) begin
            do_req(1'b1, a, $urandom, 1'b1);
            do_req(1'b0, a, 32'h0, 1'b1);
        end
        idle(4);

        chk("pending_responses", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
